sla_serial_shifter: RTL
=======================

# sla_serial_shifter

Iterative arithmetic-left-shift unit for the 16-bit ALU datapath. It accepts an operand and a shift amount through a valid/ready handshake and shifts one bit per clock. It tracks signed overflow over the whole operation and presents the registered result and overflow flag downstream through a second valid/ready handshake. It is the multi-cycle shift stage that produces the SLA result and overflow status consumed by the ALU result/flag logic.

## Interface
- WIDTH, 16, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block can accept an operation; high only in IDLE
- a  input  WIDTH  value to shift, two's complement
- b  input  WIDTH  shift amount, interpreted as unsigned
- out_valid  output  1  result/ovf hold a completed operation
- out_ready  input  1  downstream accepts the result
- result  output  WIDTH  shifted value, registered
- ovf  output  1  signed overflow occurred during the shift, registered
- busy  output  1  high in SHIFT or DONE

## Operation
- Effective count n = min(b, WIDTH), with b taken as unsigned. Any b ≥ WIDTH, including values with b[WIDTH-1]=1, saturates to WIDTH.
- Internal state: shift register sr[WIDTH-1:0], down-counter cnt of $clog2(WIDTH)+1 bits, sticky flag ovf_s.
- States: IDLE, SHIFT, DONE (3-state FSM, registered state).
- IDLE:
  - in_ready=1.
  - On in_valid: sr←a, cnt←n, ovf_s←0.
  - Next state is DONE if n==0, else SHIFT.
  - a and b are sampled only on the accept edge.
- SHIFT: each cycle:
  - ovf_s ← ovf_s | (sr[W-1] ^ sr[W-2])
  - sr ← sr<<1 (zero fill)
  - cnt ← cnt−1
  - When cnt==1 this cycle, next state is DONE.
- Entering DONE: result←final sr, ovf←final ovf_s, including the last step's contribution. out_valid=1.
- DONE: result and ovf are held stable. On out_ready, next state is IDLE.
- Overflow definition: the sign bit changes at any single-bit step. Equivalently, the top n+1 bits of a are not all equal (for n<WIDTH). Any nonzero a with n=WIDTH sets ovf.
- n==0: result=a, ovf=0.
- in_valid while not in IDLE is ignored; in_ready=0 there. Upstream must hold a/b until accepted.
- result/ovf keep their last completed values in IDLE and SHIFT. out_valid marks when they are meaningful.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, ovf=0, sr=0, cnt=0.
- Accept at rising edge T (in_valid & in_ready): out_valid first high in cycle T+1+n (n=0 → T+1; n=16 → T+17).
- SHIFT occupies exactly n cycles.
- Result handshake completes at edge U (out_valid & out_ready). in_ready is high from U+1.
- Minimum accept-to-accept interval is n+2 cycles when out_ready is tied high.
- Backpressure: out_ready low holds DONE indefinitely. result and ovf must not change.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Reset asserted in any state, including mid-SHIFT: all registers go immediately to reset values. The in-flight operation is discarded and no out_valid is produced for it.
- Reset deasserted: the first accept is possible on the next rising edge.

## Test plan
- a=0x0003, b=2, out_ready=1 → result=0x000C, ovf=0, out_valid exactly at T+3 for one cycle.
- a=0x4000, b=1 → result=0x8000, ovf=1. a=0xC000, b=1 → result=0x8000, ovf=0. a=0xE000, b=3 → result=0x0000, ovf=1.
- b=0, a=0x8001 → result=0x8001, ovf=0, out_valid at T+1. a=0x0001, b=0xFFFF → result=0x0000, ovf=1, out_valid at T+17. a=0x0000, b=20 → result=0, ovf=0.
- Backpressure: a=0x0005, b=1, out_ready low for 5 cycles while in_valid is held high with a new operand. Required: result=0x000A held stable, in_ready=0 throughout, new operand accepted only after out_ready is seen and the FSM returns to IDLE.
- Reset mid-operation: a=0x0001, b=10, assert rst in the 4th SHIFT cycle. Required: out_valid=0, result=0, ovf=0, in_ready=1 immediately. A following a=0x0001, b=1 yields 0x0002, ovf=0.
- Random regression: 10k random a/b against the reference model (result=a<<n; ovf=top n+1 bits of a not all equal, n=WIDTH → a≠0). Check result, ovf and latency for each operation.

Source files
------------

// File: rtl/sla_serial_shifter.sv
// rtl/sla_serial_shifter.sv - iterative arithmetic-left-shift unit with sticky signed overflow
//
// Accepts an operand (a) and shift amount (b) on a valid/ready handshake, shifts
// one bit per clock, and holds the result and overflow flag for a downstream
// valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept an operation (IDLE only)
//   a          value to shift, two's complement
//   b          shift amount, unsigned; saturates at WIDTH
//   out_valid  result/ovf hold a completed operation (DONE)
//   out_ready  downstream accepts the result
//   result     shifted value, registered
//   ovf        signed overflow seen at any step, registered
//   busy       high in SHIFT or DONE
module sla_serial_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] W_AS_B   = WIDTH[WIDTH-1:0];
  localparam logic [CW-1:0]    W_AS_CNT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             ovf_s;
  logic [CW-1:0]    n_eff;
  logic             accept;
  logic             step_ovf;
  logic             last_step;

  // Any b at or above WIDTH (including huge unsigned values) shifts everything out.
  always_comb begin
    if (b >= W_AS_B) begin
      n_eff = W_AS_CNT;
    end else begin
      n_eff = b[CW-1:0];
    end
  end

  assign accept    = (state == IDLE) && in_valid;
  // The sign bit changes on this step iff the two top bits differ before the shift.
  assign step_ovf  = sr[WIDTH-1] ^ sr[WIDTH-2];
  assign last_step = (state == SHIFT) && (cnt == CNT_ONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (n_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so no input-to-handshake paths.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: shift register, step counter, sticky overflow, output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      cnt    <= '0;
      ovf_s  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        sr    <= a;
        cnt   <= n_eff;
        ovf_s <= 1'b0;
        // Zero-length shift goes straight to DONE with the operand unchanged.
        if (n_eff == '0) begin
          result <= a;
          ovf    <= 1'b0;
        end
      end else if (state == SHIFT) begin
        sr    <= {sr[WIDTH-2:0], 1'b0};
        cnt   <= cnt - CNT_ONE;
        ovf_s <= ovf_s | step_ovf;
        // Capture includes the contribution of the final step itself.
        if (last_step) begin
          result <= {sr[WIDTH-2:0], 1'b0};
          ovf    <= ovf_s | step_ovf;
        end
      end
    end
  end

endmodule
